// File: rtl/constraint_verdict_collector.sv
// Collects per-constraint verdict beats for one batch of candidate vectors and
// emits a single summary record. Optional per-batch enable mask: CONS_MASK_EN.
module constraint_verdict_collector #(
    parameter int NUM_CONS = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_CONS-1:0] in_sat,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_all_sat,
    output logic [CNT_W-1:0]    out_sat_count,
    output logic [CNT_W-1:0]    out_vec_count,
    output logic [CNT_W-1:0]    out_first_fail,
    output logic [NUM_CONS-1:0] out_fail_mask,
    output logic                out_overflow,
    output logic                busy
`ifdef CONS_MASK_EN
    ,
    input  logic [NUM_CONS-1:0] cons_mask
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_REPORT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      vec_count_q, vec_count_d;
    logic [CNT_W-1:0]      sat_count_q, sat_count_d;
    logic [CNT_W-1:0]      first_fail_q, first_fail_d;
    logic [NUM_CONS-1:0]   fail_mask_q, fail_mask_d;
    logic                  overflow_q, overflow_d;
    logic                  all_sat_q, all_sat_d;
    logic                  in_ready_q, out_valid_q, busy_q;

    logic [NUM_CONS-1:0]   enable_mask;
    logic [NUM_CONS-1:0]   bit_ok;
    logic [NUM_CONS-1:0]   bit_fail;
    logic                  vec_ok;
    logic                  vec_at_max;
    logic                  sat_at_max;

`ifdef CONS_MASK_EN
    logic [NUM_CONS-1:0]   enable_mask_q, enable_mask_d;
    assign enable_mask = enable_mask_q;
`else
    assign enable_mask = '1;
`endif

    // A disabled constraint counts as satisfied and never contributes a failure bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONS; gi = gi + 1) begin : g_bit
            assign bit_ok[gi]   = in_sat[gi] | ~enable_mask[gi];
            assign bit_fail[gi] = ~in_sat[gi] & enable_mask[gi];
        end
    endgenerate

    assign vec_ok     = &bit_ok;
    assign vec_at_max = (vec_count_q == CNT_MAX);
    assign sat_at_max = (sat_count_q == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        vec_count_d  = vec_count_q;
        sat_count_d  = sat_count_q;
        first_fail_d = first_fail_q;
        fail_mask_d  = fail_mask_q;
        overflow_d   = overflow_q;
        all_sat_d    = all_sat_q;
`ifdef CONS_MASK_EN
        enable_mask_d = enable_mask_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ACCUM;
                    vec_count_d  = '0;
                    sat_count_d  = '0;
                    first_fail_d = CNT_MAX;
                    fail_mask_d  = '0;
                    overflow_d   = 1'b0;
                    all_sat_d    = 1'b0;
`ifdef CONS_MASK_EN
                    enable_mask_d = cons_mask;
`endif
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    // Counters stick at their maximum; a blocked increment marks overflow.
                    if (vec_at_max) begin
                        overflow_d = 1'b1;
                    end else begin
                        vec_count_d = vec_count_q + CNT_ONE;
                    end
                    if (vec_ok) begin
                        if (sat_at_max) begin
                            overflow_d = 1'b1;
                        end else begin
                            sat_count_d = sat_count_q + CNT_ONE;
                        end
                    end else if (first_fail_q == CNT_MAX) begin
                        first_fail_d = vec_count_q;
                    end
                    fail_mask_d = fail_mask_q | bit_fail;
                    if (in_last) begin
                        state_d = ST_REPORT;
                    end
                end
                all_sat_d = (sat_count_d == vec_count_d) && !overflow_d;
            end
            ST_REPORT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_count_q  <= '0;
            sat_count_q  <= '0;
            first_fail_q <= CNT_MAX;
            fail_mask_q  <= '0;
            overflow_q   <= 1'b0;
            all_sat_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CONS_MASK_EN
            enable_mask_q <= '1;
`endif
        end else begin
            state_q      <= state_d;
            vec_count_q  <= vec_count_d;
            sat_count_q  <= sat_count_d;
            first_fail_q <= first_fail_d;
            fail_mask_q  <= fail_mask_d;
            overflow_q   <= overflow_d;
            all_sat_q    <= all_sat_d;
            // Handshake flags are decoded from the next state so they line up with state_q.
            in_ready_q   <= (state_d == ST_ACCUM);
            out_valid_q  <= (state_d == ST_REPORT);
            busy_q       <= (state_d != ST_IDLE);
`ifdef CONS_MASK_EN
            enable_mask_q <= enable_mask_d;
`endif
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign busy           = busy_q;
    assign out_all_sat    = all_sat_q;
    assign out_sat_count  = sat_count_q;
    assign out_vec_count  = vec_count_q;
    assign out_first_fail = first_fail_q;
    assign out_fail_mask  = fail_mask_q;
    assign out_overflow   = overflow_q;

endmodule

// File: tb/tb_constraint_verdict_collector.sv
// Bench for constraint_verdict_collector: directed literal checks plus random
// traffic against a batch-level model, on a 16-bit and a 4-bit counter instance.
module tb_constraint_verdict_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_sat = '1;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
`ifdef CONS_MASK_EN
    logic [31:0] cons_mask = '1;
`endif

    logic        in_ready, out_valid, out_all_sat, out_overflow, busy;
    logic [15:0] out_sat_count, out_vec_count, out_first_fail;
    logic [31:0] out_fail_mask;

    logic        in_ready4, out_valid4, out_all_sat4, out_overflow4, busy4;
    logic [3:0]  out_sat_count4, out_vec_count4, out_first_fail4;
    logic [31:0] out_fail_mask4;

    int total = 0;
    int bad = 0;
    int batches = 0;

    always #5 clk = ~clk;

    constraint_verdict_collector #(.NUM_CONS(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_sat(in_sat), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_all_sat(out_all_sat), .out_sat_count(out_sat_count), .out_vec_count(out_vec_count),
        .out_first_fail(out_first_fail), .out_fail_mask(out_fail_mask),
        .out_overflow(out_overflow), .busy(busy)
`ifdef CONS_MASK_EN
        , .cons_mask(cons_mask)
`endif
    );

    constraint_verdict_collector #(.NUM_CONS(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_sat(in_sat), .in_last(in_last), .out_valid(out_valid4), .out_ready(out_ready),
        .out_all_sat(out_all_sat4), .out_sat_count(out_sat_count4), .out_vec_count(out_vec_count4),
        .out_first_fail(out_first_fail4), .out_fail_mask(out_fail_mask4),
        .out_overflow(out_overflow4), .busy(busy4)
`ifdef CONS_MASK_EN
        , .cons_mask(cons_mask)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- batch-level model ----------------
    int          ph = 0;            // 0 idle, 1 collecting, 2 reporting
    logic [31:0] beats[$];
    logic [31:0] m_en = '1;
    int          e_vec = 0, e_sat = 0, e_ff = 65535;
    int          e4_vec = 0, e4_sat = 0, e4_ff = 15;
    logic        e_all = 0, e_ovf = 0, e4_all = 0, e4_ovf = 0;
    logic [31:0] e_mask = '0;

    task automatic summarize(input int maxv, output int vec, output int sat, output int ff,
                             output logic all_ok, output logic ovf, output logic [31:0] fm);
        int n, nsat, first;
        logic [31:0] fails;
        n = beats.size();
        nsat = 0;
        first = -1;
        fm = '0;
        foreach (beats[i]) begin
            fails = ~beats[i] & m_en;
            if (fails == 0) nsat++;
            else if (first < 0) first = i;
            fm |= fails;
        end
        vec = (n > maxv) ? maxv : n;
        sat = (nsat > maxv) ? maxv : nsat;
        ovf = (n > maxv) || (nsat > maxv);
        ff = (first < 0 || first > maxv) ? maxv : first;
        all_ok = (sat == vec) && !ovf;
    endtask

    task automatic model_clear(input logic from_reset);
        beats.delete();
        e_vec = 0; e_sat = 0; e_ff = 65535; e_all = 0; e_ovf = 0; e_mask = '0;
        e4_vec = 0; e4_sat = 0; e4_ff = 15; e4_all = 0; e4_ovf = 0;
        if (from_reset) begin
            ph = 0;
            m_en = '1;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_clear(1'b1);
        end else begin
            case (ph)
                0: if (start) begin
                    model_clear(1'b0);
`ifdef CONS_MASK_EN
                    m_en = cons_mask;
`else
                    m_en = '1;
`endif
                    ph = 1;
                end
                1: if (in_valid) begin
                    logic [31:0] fm4;
                    beats.push_back(in_sat);
                    if (in_last) begin
                        summarize(65535, e_vec, e_sat, e_ff, e_all, e_ovf, e_mask);
                        summarize(15, e4_vec, e4_sat, e4_ff, e4_all, e4_ovf, fm4);
                        ph = 2;
                    end
                end
                default: if (out_ready) begin
                    batches++;
                    $display("batch %0d: vec=%0d sat=%0d first_fail=%0h mask=%h all=%0d ovf=%0d",
                             batches, e_vec, e_sat, e_ff, e_mask, e_all, e_ovf);
                    ph = 0;
                end
            endcase
        end
    end

    // Compare process: handshake flags every cycle, summary whenever not collecting.
    always @(negedge clk) begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, ph == 1});
        chk("out_valid", {63'd0, out_valid}, {63'd0, ph == 2});
        chk("busy", {63'd0, busy}, {63'd0, ph != 0});
        chk("in_ready4", {63'd0, in_ready4}, {63'd0, ph == 1});
        chk("out_valid4", {63'd0, out_valid4}, {63'd0, ph == 2});
        if (ph != 1) begin
            chk("vec_count", 64'(out_vec_count), 64'(e_vec));
            chk("sat_count", 64'(out_sat_count), 64'(e_sat));
            chk("first_fail", 64'(out_first_fail), 64'(e_ff));
            chk("fail_mask", 64'(out_fail_mask), 64'(e_mask));
            chk("all_sat", {63'd0, out_all_sat}, {63'd0, e_all});
            chk("overflow", {63'd0, out_overflow}, {63'd0, e_ovf});
            chk("vec_count4", 64'(out_vec_count4), 64'(e4_vec));
            chk("sat_count4", 64'(out_sat_count4), 64'(e4_sat));
            chk("first_fail4", 64'(out_first_fail4), 64'(e4_ff));
            chk("fail_mask4", 64'(out_fail_mask4), 64'(e_mask));
            chk("all_sat4", {63'd0, out_all_sat4}, {63'd0, e4_all});
            chk("overflow4", {63'd0, out_overflow4}, {63'd0, e4_ovf});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] s, input logic last);
        in_valid = 1'b1;
        in_sat = s;
        in_last = last;
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL %s_timeout: got out_valid=0 expected 1 within 50 cycles", name);
        end
    endtask

    function automatic logic [31:0] rnd_sat();
        logic [31:0] one = 32'h1;
        case ($urandom % 4)
            0, 1: return '1;
            2: return ~(one << ($urandom % 32));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] one = 32'h1;
        repeat (3) tick();
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_first_fail", 64'(out_first_fail), 64'hFFFF);
        chk("rst_all_sat", {63'd0, out_all_sat}, 64'd0);
        rst = 1'b0;
        tick();

        // Four clean beats
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) beat('1, i == 3);
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_vec", 64'(out_vec_count), 64'd4);
        chk("t1_sat", 64'(out_sat_count), 64'd4);
        chk("t1_all_sat", {63'd0, out_all_sat}, 64'd1);
        chk("t1_first_fail", 64'(out_first_fail), 64'hFFFF);
        chk("t1_mask", 64'(out_fail_mask), 64'd0);
        tick();

        // Two failing beats, then a long stall in REPORT
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 5; i++)
            beat((i == 2) ? ~(one << 22) : (i == 4) ? ~(one << 3) : '1, i == 4);
        wait_valid("t2");
        chk("t2_sat", 64'(out_sat_count), 64'd3);
        chk("t2_first_fail", 64'(out_first_fail), 64'd2);
        chk("t2_mask", 64'(out_fail_mask), 64'h0040_0008);
        chk("t2_all_sat", {63'd0, out_all_sat}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            start = ~i[0];
            tick();
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_sat", 64'(out_sat_count), 64'd3);
        end
        in_valid = 1'b0;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("hs_start_busy", {63'd0, busy}, 64'd0);
        chk("hs_retain_sat", 64'(out_sat_count), 64'd3);

        // Reset in the middle of a batch
        pulse_start();
        for (int i = 0; i < 3; i++) beat('1, 1'b0);
        rst = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_vec", 64'(out_vec_count), 64'd0);
        chk("arst_first_fail", 64'(out_first_fail), 64'hFFFF);
        tick();
        rst = 1'b0;
        pulse_start();
        beat('1, 1'b1);
        chk("post_rst_vec", 64'(out_vec_count), 64'd1);
        tick();

        // 20 passing beats: the 4-bit instance saturates
        pulse_start();
        for (int i = 0; i < 20; i++) beat('1, i == 19);
        chk("ovf4_vec", 64'(out_vec_count4), 64'd15);
        chk("ovf4_sat", 64'(out_sat_count4), 64'd15);
        chk("ovf4_flag", {63'd0, out_overflow4}, 64'd1);
        chk("ovf4_all_sat", {63'd0, out_all_sat4}, 64'd0);
        chk("ovf16_vec", 64'(out_vec_count), 64'd20);
        tick();

`ifdef CONS_MASK_EN
        cons_mask = ~(one << 22);
        pulse_start();
        cons_mask = '1;
        beat(~(one << 22), 1'b1);
        chk("mask_sat", 64'(out_sat_count), 64'd1);
        chk("mask_fail_mask", 64'(out_fail_mask), 64'd0);
        tick();
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 6) == 0;
            in_valid = ($urandom % 3) != 0;
            in_sat = rnd_sat();
            in_last = ($urandom % 5) == 0;
            out_ready = ($urandom % 3) != 0;
`ifdef CONS_MASK_EN
            cons_mask = ($urandom % 2) ? '1 : ~(one << ($urandom % 32));
`endif
            if (($urandom % 500) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
